adc_capture_ctrl: RTL
=====================

// Module: adc_capture_ctrl
// PURPOSE
//  Sequences one capture through the 2^ADDR_WIDTH-deep ADC sample buffer RAM.
//  Uses the RAM as a ring, arms on request, detects a level/edge or software trigger,
//  and records a fixed number of pre-trigger and post-trigger samples.
//  Then streams the buffer back out, oldest first, over valid/ready; the buffer read latency is 1 cycle.
//  Sits between the ADC sample stream and the buffer RAM; the host/readout logic consumes the out_* stream.
// PARAMETERS
//  DATA_WIDTH  8   sample width; matches the buffer RAM
//  ADDR_WIDTH  12  buffer address width; DEPTH = 2**ADDR_WIDTH
// PORTS
//  clock           in  1   single clock for all logic
//  reset_n         in  1   asynchronous, active-low reset
//  arm             in  1   pulse: start capture (honoured in IDLE only)
//  abort           in  1   pulse: return to IDLE from any state
//  sw_trigger      in  1   pulse: force trigger (honoured in ARMED)
//  trig_rising     in  1   1 = rising-edge trigger, 0 = falling-edge trigger
//  trig_level      in  DW  trigger threshold, unsigned
//  pretrig_len     in  AW  pre-trigger samples, 0..DEPTH-1; sampled on arm
//  sample_valid    in  1   ADC sample strobe
//  sample_data     in  DW  ADC sample
//  buf_write_en    out 1   buffer RAM write enable
//  buf_write_addr  out AW  buffer RAM write address
//  buf_write_data  out DW  buffer RAM write data
//  buf_read_addr   out AW  buffer RAM read address
//  buf_read_data   in  DW  buffer RAM data; valid 1 cycle after buf_read_addr
//  rd_start        in  1   pulse: begin readout (honoured in DONE only)
//  out_valid       out 1   readout word valid
//  out_ready       in  1   consumer accepts word
//  out_data        out DW  readout word
//  out_last        out 1   high with the DEPTH-th (final) word
//  busy            out 1   state != IDLE
//  done            out 1   state == DONE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; wr_ptr=0; trigger flags cleared. abort has the same effect, synchronously, on the next edge.
//  Writes: every sample_valid in PRETRIG/ARMED/POSTTRIG asserts buf_write_en on the same cycle.
//    buf_write_addr=wr_ptr, buf_write_data=sample_data; wr_ptr then increments mod DEPTH. No other state writes.
//  IDLE   -> PRETRIG on arm: wr_ptr<=0, latch pretrig_len, clear prev_valid and sw_pend.
//  PRETRIG: counts written samples; -> ARMED once the count reaches pretrig_len (immediately if 0). Triggers ignored.
//  ARMED: writes continue as a ring. Trigger on a sample_valid cycle when either holds:
//    sw_pend is set;
//    or prev_valid and (rising ? prev<lvl && cur>=lvl : prev>lvl && cur<=lvl).
//  That sample is the trigger sample. trig_addr<=its address; -> POSTTRIG.
//  prev = last written sample; prev_valid is set by any write since arm. sw_trigger in ARMED sets sw_pend.
//  POSTTRIG: the trigger sample plus the following samples total DEPTH-pretrig_len writes; -> DONE on the last one.
//  DONE: start_addr = (trig_addr - pretrig_len) mod DEPTH; -> READOUT on rd_start.
//  READOUT: emits DEPTH words from start_addr, incrementing mod DEPTH. First out_valid is 2 cycles after rd_start.
//    Sustains 1 word/cycle while out_ready=1.
//    out_data and out_last are held stable while out_valid && !out_ready.
//    Words are never dropped or duplicated; a prefetch/skid register covers the RAM latency.
//    -> IDLE on the cycle the out_last word is accepted.
//  arm outside IDLE, rd_start outside DONE, and sw_trigger outside ARMED are ignored.
//  sample_valid is ignored in IDLE/DONE/READOUT.
//  Reset or abort mid-READOUT drops out_valid with no further words; buffer contents are not cleared.
// STRUCTURE
//  Package adc_capture_pkg: state enum (IDLE, PRETRIG, ARMED, POSTTRIG, DONE, READOUT).
//  The same package holds a function for the edge-trigger compare.
//  Sub-module adc_readout_skid: 2-entry buffer adapting the 1-cycle RAM read latency to valid/ready.
// TESTING (ADDR_WIDTH=4, DEPTH=16)
//  1. pretrig=4, rising, lvl=0x10, arm, ramp 0x00,0x01,...:
//     trigger on 0x10 at addr0; readout = 0x0C..0x1B; out_last on 0x1B.
//  2. pretrig=2, falling, lvl=0x40, samples 0x50,0x48,0x41,0x40,...:
//     trigger on 0x40; readout starts 0x48,0x41,0x40; 16 words total.
//  3. pretrig=0, arm then sw_trigger, samples 0xA0..0xAF:
//     DONE after the 16th write; readout 0xA0..0xAF from addr0.
//  4. Readout with out_ready pattern 1,0,0,1,0,1...:
//     each word appears exactly once, in order; out_data stable during stalls.
//  5. abort in POSTTRIG: buf_write_en=0 and busy=0 from the next cycle.
//     reset_n low mid-READOUT: out_valid=0 immediately.
//  6. sample_valid gaps, and arm/rd_start pulses in wrong states:
//     wr_ptr advances only on sample_valid; state is unaffected.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC capture sequencer: controller states and the edge-trigger compare.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRETRIG  = 3'd1,
        ARMED    = 3'd2,
        POSTTRIG = 3'd3,
        DONE     = 3'd4,
        READOUT  = 3'd5
    } state_t;

    localparam int CMP_W = 64;
    typedef logic [CMP_W-1:0] cmp_t;

    // Operands are zero-extended by the caller, so the compare stays unsigned at any sample width.
    function automatic logic edge_hit(
        input logic rising,
        input cmp_t prev,
        input cmp_t cur,
        input cmp_t lvl
    );
        if (rising) begin
            return (prev < lvl) && (cur >= lvl);
        end
        return (prev > lvl) && (cur <= lvl);
    endfunction

endpackage

// File: rtl/adc_readout_skid.sv
// Two-entry buffer turning the 1-cycle RAM read stream into a valid/ready stream.
// Latency: 1 cycle from push to o_pop_vld.
// Backpressure: head word held while !i_pop_rdy; upstream must keep o_count + in-flight <= 2.
module adc_readout_skid #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop_rdy,
    output logic         o_pop_vld,
    output logic [W-1:0] o_pop_dat,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_dat0;
    logic [W-1:0] r_dat1;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop     = (r_cnt != 2'd0) && i_pop_rdy;
    assign o_pop_vld = (r_cnt != 2'd0);
    assign o_pop_dat = o_pop_vld ? r_dat0 : '0;
    assign o_count   = r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 2'd0;
            r_dat0 <= '0;
            r_dat1 <= '0;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end else begin
            case ({i_push_vld, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_dat0 <= i_push_dat;
                    end else begin
                        r_dat1 <= i_push_dat;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_dat0 <= r_dat1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop keeps occupancy; only the head/tail shift.
                    if (r_cnt == 2'd2) begin
                        r_dat0 <= r_dat1;
                        r_dat1 <= i_push_dat;
                    end else begin
                        r_dat0 <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Ring-buffer ADC capture: arm, pre-trigger fill, edge/software trigger, post-trigger fill, readout.
// Latency: RAM write same cycle as sample_valid; first out_valid 2 cycles after rd_start.
// Backpressure: readout stalls on !out_ready with out_data/out_last held; sample input has none.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sw_trigger,
    input  logic                  trig_rising,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  buf_write_en,
    output logic [ADDR_WIDTH-1:0] buf_write_addr,
    output logic [DATA_WIDTH-1:0] buf_write_data,
    output logic [ADDR_WIDTH-1:0] buf_read_addr,
    input  logic [DATA_WIDTH-1:0] buf_read_data,
    input  logic                  rd_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_trig_addr;
    logic [AW-1:0] r_pre_len;
    logic [AW-1:0] r_rd_addr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_issued;
    logic [DW-1:0] r_prev;
    logic          r_prev_vld;
    logic          r_sw_pend;
    logic          r_inflight;
    logic          r_inflight_last;

    logic          w_wr_en;
    logic          w_edge;
    logic          w_trig;
    logic [AW:0]   w_cnt_inc;
    logic [AW:0]   w_post_total;
    logic [AW-1:0] w_start_addr;
    logic          w_issue;
    logic          w_space;
    logic [1:0]    w_occ;
    logic          w_pop;
    logic          w_pop_last;
    logic          w_skid_vld;
    logic [DW:0]   w_skid_dat;
    logic [1:0]    w_skid_cnt;

    assign w_wr_en      = sample_valid &&
                          ((r_state == PRETRIG) || (r_state == ARMED) || (r_state == POSTTRIG));
    assign w_edge       = r_prev_vld && edge_hit(trig_rising, cmp_t'(r_prev),
                                                 cmp_t'(sample_data), cmp_t'(trig_level));
    assign w_trig       = (r_state == ARMED) && sample_valid && (r_sw_pend || w_edge);
    assign w_cnt_inc    = r_cnt + ONE;
    assign w_post_total = DEPTH - {1'b0, r_pre_len};
    assign w_start_addr = r_trig_addr - r_pre_len;

    assign w_pop      = w_skid_vld && out_ready;
    assign w_pop_last = w_pop && w_skid_dat[DW];

    // Words held plus the one returning from RAM may never exceed the two skid slots.
    assign w_occ   = w_skid_cnt + {1'b0, r_inflight};
    assign w_space = (w_occ != 2'd2) || w_pop;
    assign w_issue = w_space && (((r_state == DONE) && rd_start) ||
                                 ((r_state == READOUT) && (r_issued != DEPTH)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (arm) w_state_nxt = PRETRIG;
                PRETRIG:  if ((r_pre_len == '0) ||
                              (w_wr_en && (w_cnt_inc == {1'b0, r_pre_len})))
                              w_state_nxt = ARMED;
                ARMED:    if (w_trig) w_state_nxt = (w_post_total == ONE) ? DONE : POSTTRIG;
                POSTTRIG: if (w_wr_en && (w_cnt_inc == w_post_total)) w_state_nxt = DONE;
                DONE:     if (rd_start) w_state_nxt = READOUT;
                READOUT:  if (w_pop_last) w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        buf_write_en   = 1'b0;
        buf_write_addr = r_wr_ptr;
        buf_write_data = '0;
        buf_read_addr  = r_rd_addr;
        busy           = (r_state != IDLE);
        done           = (r_state == DONE);
        if (w_wr_en) begin
            buf_write_en   = 1'b1;
            buf_write_data = sample_data;
        end
        // Presenting start_addr throughout DONE lets the first read issue on the rd_start edge.
        if (r_state == DONE) begin
            buf_read_addr = w_start_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr        <= '0;
            r_trig_addr     <= '0;
            r_pre_len       <= '0;
            r_rd_addr       <= '0;
            r_cnt           <= '0;
            r_issued        <= '0;
            r_prev          <= '0;
            r_prev_vld      <= 1'b0;
            r_sw_pend       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else if (abort) begin
            r_wr_ptr        <= '0;
            r_trig_addr     <= '0;
            r_pre_len       <= '0;
            r_rd_addr       <= '0;
            r_cnt           <= '0;
            r_issued        <= '0;
            r_prev_vld      <= 1'b0;
            r_sw_pend       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_prev     <= sample_data;
                r_prev_vld <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_wr_ptr   <= '0;
                        r_pre_len  <= pretrig_len;
                        r_prev_vld <= 1'b0;
                        r_sw_pend  <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                PRETRIG, POSTTRIG: begin
                    if (w_wr_en) r_cnt <= w_cnt_inc;
                end
                ARMED: begin
                    if (sw_trigger) r_sw_pend <= 1'b1;
                    if (w_trig) begin
                        r_trig_addr <= r_wr_ptr;
                        r_cnt       <= ONE;
                        r_sw_pend   <= 1'b0;
                    end
                end
                default: ;
            endcase

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_state == READOUT) && (r_issued == DEPTH - ONE);
            if (w_issue) begin
                r_issued  <= (r_state == DONE) ? ONE : (r_issued + ONE);
                r_rd_addr <= buf_read_addr + 1'b1;
            end
        end
    end

    adc_readout_skid #(
        .W (DW + 1)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_flush    (abort),
        .i_push_vld (r_inflight),
        .i_push_dat ({r_inflight_last, buf_read_data}),
        .i_pop_rdy  (out_ready),
        .o_pop_vld  (w_skid_vld),
        .o_pop_dat  (w_skid_dat),
        .o_count    (w_skid_cnt)
    );

    assign out_valid = w_skid_vld;
    assign out_data  = w_skid_dat[DW-1:0];
    assign out_last  = w_skid_dat[DW];

endmodule
